// File: rtl/regfile_dbg_arb_pkg.sv
// Shared types for the GPR debug-port arbiter: FSM state encoding and register index width.
package regfile_dbg_arb_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_RESTORE
  } arb_state_e;

endpackage

// File: rtl/regfile_dbg_arb.sv
// Arbitrates GPR read port 1 and the write port between the core pipeline and a debug requester.
// Optional: define REGFILE_DBG_ARB_X0_ERR_EN to block debug writes to x0 and flag them with dbg_resp_err_op.
module regfile_dbg_arb
  import regfile_dbg_arb_pkg::*;
#(
  parameter int XW           = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [REG_ADDR_W-1:0] core_rd_addr1_ip,
  input  logic [REG_ADDR_W-1:0] core_rd_addr2_ip,
  output logic [XW-1:0]         core_rd_data1_op,
  output logic [XW-1:0]         core_rd_data2_op,
  input  logic [REG_ADDR_W-1:0] core_wr_addr_ip,
  input  logic [XW-1:0]         core_wr_data_ip,
  input  logic                  core_wr_en_ip,
  output logic                  core_stall_op,

  output logic [REG_ADDR_W-1:0] rf_rd_addr1_op,
  output logic [REG_ADDR_W-1:0] rf_rd_addr2_op,
  input  logic [XW-1:0]         rf_rd_data1_ip,
  input  logic [XW-1:0]         rf_rd_data2_ip,
  output logic [REG_ADDR_W-1:0] rf_wr_addr_op,
  output logic [XW-1:0]         rf_wr_data_op,
  output logic                  rf_wr_en_op,

  input  logic                  dbg_req_valid_ip,
  output logic                  dbg_req_ready_op,
  input  logic                  dbg_req_we_ip,
  input  logic [REG_ADDR_W-1:0] dbg_req_addr_ip,
  input  logic [XW-1:0]         dbg_req_wdata_ip,
  output logic                  dbg_resp_valid_op,
  input  logic                  dbg_resp_ready_ip,
  output logic [XW-1:0]         dbg_resp_rdata_op,
  output logic                  dbg_resp_err_op
);

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  stall_q;
  logic                  resp_valid_q;
  logic [XW-1:0]         rdata_q;
  logic                  err_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] addr_q;

  logic                  x0_wr_blk;
  logic                  x0_err;

`ifdef REGFILE_DBG_ARB_X0_ERR_EN
  assign x0_wr_blk = dbg_req_we_ip && (dbg_req_addr_ip == '0);
  assign x0_err    = we_q && (addr_q == '0);
`else
  assign x0_wr_blk = 1'b0;
  assign x0_err    = 1'b0;
`endif

  // Read port 2 and both read data paths are never arbitrated.
  assign rf_rd_addr2_op    = core_rd_addr2_ip;
  assign core_rd_data1_op  = rf_rd_data1_ip;
  assign core_rd_data2_op  = rf_rd_data2_ip;

  assign core_stall_op     = stall_q;
  assign dbg_req_ready_op  = (state_q == ST_ACCESS);
  assign dbg_resp_valid_op = resp_valid_q;
  assign dbg_resp_rdata_op = rdata_q;
  assign dbg_resp_err_op   = err_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (dbg_req_valid_ip) state_d = (DRAIN_CYCLES == 0) ? ST_ACCESS : ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 3'd1;
        if (!dbg_req_valid_ip)        state_d = ST_RESTORE;
        else if (cnt_q == DRAIN_LAST) state_d = ST_ACCESS;
      end
      ST_ACCESS:  state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_RESP;
      ST_RESP:    if (dbg_resp_ready_ip) state_d = ST_RESTORE;
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_rd_addr1_op = core_rd_addr1_ip;
    rf_wr_addr_op  = core_wr_addr_ip;
    rf_wr_data_op  = core_wr_data_ip;
    rf_wr_en_op    = core_wr_en_ip;
    case (state_q)
      ST_ACCESS: begin
        rf_rd_addr1_op = dbg_req_addr_ip;
        rf_wr_addr_op  = dbg_req_addr_ip;
        rf_wr_data_op  = dbg_req_wdata_ip;
        rf_wr_en_op    = dbg_req_we_ip && !x0_wr_blk;
      end
      ST_WAIT: begin
        // The registered read issued in ACCESS returns now; keep the address steady.
        rf_rd_addr1_op = addr_q;
        rf_wr_en_op    = 1'b0;
      end
      ST_RESP, ST_RESTORE: rf_wr_en_op = 1'b0;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stall_q      <= (state_d != ST_IDLE);
      resp_valid_q <= (state_d == ST_RESP);
      if (state_q == ST_ACCESS) begin
        we_q   <= dbg_req_we_ip;
        addr_q <= dbg_req_addr_ip;
      end
      if (state_q == ST_WAIT) begin
        rdata_q <= we_q ? '0 : rf_rd_data1_ip;
        err_q   <= x0_err;
      end
    end
  end

endmodule
